// File: rtl/gam_learn_recall_ctrl.sv
// Learn/recall sequencer for the memory layer: streams training vectors with a
// fixed settle window, then serves recall queries one at a time.
module gam_learn_recall_ctrl #(
  parameter int NODE_W       = 128,
  parameter int CLASS_W      = 8,
  parameter int HOLD_CYCLES  = 10,
  parameter int MAX_PATTERNS = 16,
  parameter int CNT_W        = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               learn_start,
  input  logic               pat_valid,
  output logic               pat_ready,
  input  logic [NODE_W-1:0]  pat_data,
  input  logic [CLASS_W-1:0] pat_class,
  input  logic               pat_last,
  input  logic               recall_req,
  output logic               recall_ready,
  input  logic [NODE_W-1:0]  recall_data,
  input  logic [31:0]        recall_tk,
  output logic               recall_ack,
  output logic [NODE_W-1:0]  ml_x,
  output logic [31:0]        ml_c,
  output logic               ml_reset,
  output logic               ml_learning_done,
  output logic               ml_recall,
  output logic [31:0]        rc_tk,
  output logic               busy,
  output logic               learn_done,
  output logic [CNT_W-1:0]   pattern_count,
  output logic               err_overflow
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_PATTERNS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MLRST  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_RIDLE  = 3'd5;
  localparam logic [2:0] S_RHOLD  = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [HC_W-1:0]    hcnt_q, hcnt_d;
  logic               last_q, last_d;
  logic [NODE_W-1:0]  ml_x_q, ml_x_d;
  logic [31:0]        ml_c_q, ml_c_d;
  logic [31:0]        rc_tk_q, rc_tk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               ack_q, ack_d;
  logic               pat_ready_q, pat_ready_d;
  logic               recall_ready_q, recall_ready_d;
  logic               busy_q, busy_d;
  logic               learn_done_q, learn_done_d;
  logic               ml_reset_q, ml_reset_d;
  logic               ml_ld_q, ml_ld_d;
  logic               ml_recall_q, ml_recall_d;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    last_d  = last_q;
    ml_x_d  = ml_x_q;
    ml_c_d  = ml_c_q;
    rc_tk_d = rc_tk_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (learn_start) begin
        state_d = S_MLRST;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      S_MLRST: state_d = S_LOAD;
      S_LOAD: if (pat_valid && pat_ready_q) begin
        ml_x_d  = pat_data;
        ml_c_d  = 32'(pat_class);
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        last_d  = pat_last;
        hcnt_d  = HOLD_LAST;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - HC_W'(1);
        end else if (last_q) begin
          state_d = S_FINISH;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FINISH: state_d = S_RIDLE;
      S_RIDLE: begin
        // a retrain request wins over a query arriving in the same cycle
        if (learn_start) begin
          state_d = S_MLRST;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (recall_req && recall_ready_q) begin
          ml_x_d  = recall_data;
          rc_tk_d = recall_tk;
          hcnt_d  = HOLD_LAST;
          state_d = S_RHOLD;
        end
      end
      S_RHOLD: begin
        if (hcnt_q != '0) hcnt_d = hcnt_q - HC_W'(1);
        else              state_d = S_RIDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are decoded from the next state so they line up with it
    ack_d          = (state_d == S_RHOLD) && (hcnt_d == '0);
    pat_ready_d    = (state_d == S_LOAD);
    recall_ready_d = (state_d == S_RIDLE);
    busy_d         = (state_d != S_IDLE) && (state_d != S_RIDLE);
    learn_done_d   = (state_d == S_RIDLE);
    ml_reset_d     = (state_d == S_IDLE) || (state_d == S_MLRST);
    ml_ld_d        = (state_d != S_LOAD) && (state_d != S_HOLD);
    ml_recall_d    = (state_d == S_RIDLE) || (state_d == S_RHOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      hcnt_q         <= '0;
      last_q         <= 1'b0;
      ml_x_q         <= '0;
      ml_c_q         <= '0;
      rc_tk_q        <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      ack_q          <= 1'b0;
      pat_ready_q    <= 1'b0;
      recall_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      learn_done_q   <= 1'b0;
      ml_reset_q     <= 1'b1;
      ml_ld_q        <= 1'b1;
      ml_recall_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      hcnt_q         <= hcnt_d;
      last_q         <= last_d;
      ml_x_q         <= ml_x_d;
      ml_c_q         <= ml_c_d;
      rc_tk_q        <= rc_tk_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      ack_q          <= ack_d;
      pat_ready_q    <= pat_ready_d;
      recall_ready_q <= recall_ready_d;
      busy_q         <= busy_d;
      learn_done_q   <= learn_done_d;
      ml_reset_q     <= ml_reset_d;
      ml_ld_q        <= ml_ld_d;
      ml_recall_q    <= ml_recall_d;
    end
  end

  assign pat_ready        = pat_ready_q;
  assign recall_ready     = recall_ready_q;
  assign recall_ack       = ack_q;
  assign ml_x             = ml_x_q;
  assign ml_c             = ml_c_q;
  assign rc_tk            = rc_tk_q;
  assign ml_reset         = ml_reset_q;
  assign ml_learning_done = ml_ld_q;
  assign ml_recall        = ml_recall_q;
  assign busy             = busy_q;
  assign learn_done       = learn_done_q;
  assign pattern_count    = cnt_q;
  assign err_overflow     = err_q;

endmodule

// File: tb/tb_gam_learn_recall_ctrl.sv
// Bench for gam_learn_recall_ctrl: scoreboarded training/recall streams, a recall
// vector table, and hand sequences for retrain priority, overflow and async reset.
module tb_gam_learn_recall_ctrl;
  localparam int NODE_W = 128, CLASS_W = 8, HC = 10, MAXP = 4, CNT_W = 5;

  logic clk = 1'b0, reset;
  logic learn_start, pat_valid, pat_ready, pat_last, recall_req, recall_ready, recall_ack;
  logic [NODE_W-1:0]  pat_data, recall_data, ml_x;
  logic [CLASS_W-1:0] pat_class;
  logic [31:0]        recall_tk, ml_c, rc_tk;
  logic ml_reset, ml_learning_done, ml_recall, busy, learn_done, err_overflow;
  logic [CNT_W-1:0]   pattern_count;

  always #5 clk = ~clk;

  gam_learn_recall_ctrl #(.NODE_W(NODE_W), .CLASS_W(CLASS_W), .HOLD_CYCLES(HC),
                          .MAX_PATTERNS(MAXP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .learn_start(learn_start), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .pat_data(pat_data), .pat_class(pat_class), .pat_last(pat_last),
    .recall_req(recall_req), .recall_ready(recall_ready), .recall_data(recall_data),
    .recall_tk(recall_tk), .recall_ack(recall_ack), .ml_x(ml_x), .ml_c(ml_c),
    .ml_reset(ml_reset), .ml_learning_done(ml_learning_done), .ml_recall(ml_recall),
    .rc_tk(rc_tk), .busy(busy), .learn_done(learn_done), .pattern_count(pattern_count),
    .err_overflow(err_overflow));

  // {ml_reset, ml_learning_done, ml_recall, pat_ready, recall_ready, recall_ack, busy, learn_done, err_overflow}
  localparam logic [8:0] F_RESET = 9'b110_000_000;
  localparam logic [8:0] F_MLRST = 9'b110_000_100;
  localparam logic [8:0] F_LOAD  = 9'b000_100_100;
  localparam logic [8:0] F_RIDLE = 9'b011_010_010;

  typedef struct { logic [NODE_W-1:0] x; logic [31:0] aux; } exp_t;
  typedef struct { logic [NODE_W-1:0] x; logic [31:0] tk; int lat; } rv_t;

  exp_t sb[$];
  rv_t  rtab[4];
  logic [NODE_W-1:0]  tr_x[8];
  logic [CLASS_W-1:0] tr_c[8];
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [NODE_W-1:0] got, input logic [NODE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [8:0] flags();
    return {ml_reset, ml_learning_done, ml_recall, pat_ready, recall_ready, recall_ack,
            busy, learn_done, err_overflow};
  endfunction

  task automatic start_learn();
    learn_start = 1'b1;
    @(negedge clk);
    learn_start = 1'b0;
    chk("mlrst flags", flags(), F_MLRST);
    chk("mlrst count", pattern_count, 0);
  endtask

  // streams tr_x/tr_c with valid held high until the controller reaches recall-idle
  task automatic train(input int n, input bit use_last, input int exp_acc, input bit exp_err);
    int acc = 0, t = 0, t_acc = 0, t_ld = -1;
    bit pend = 0;
    logic [NODE_W-1:0] cur_x = '0;
    exp_t e;
    pat_valid = 1'b1; pat_data = tr_x[0]; pat_class = tr_c[0]; pat_last = use_last && (n == 1);
    if (pat_valid && pat_ready) begin sb.push_back('{pat_data, 32'(pat_class)}); pend = 1; end
    while (!learn_done && t < 300) begin
      @(negedge clk); t++;
      if (pend) begin
        e = sb.pop_front(); acc++;
        chk("train ml_x", ml_x, e.x);
        chk("train ml_c", ml_c, e.aux);
        chk("train count", pattern_count, acc);
        if (acc > 1) chk("accept spacing", t - t_acc, HC + 1);
        t_acc = t; cur_x = e.x; pend = 0;
        if (acc < n) begin
          pat_data = tr_x[acc]; pat_class = tr_c[acc]; pat_last = use_last && (acc == n - 1);
        end else pat_valid = 1'b0;
      end else if (acc > 0 && busy) chk("hold stable", ml_x, cur_x);
      if (acc > 0 && ml_learning_done && t_ld < 0) t_ld = t;
      if (pat_valid && pat_ready) begin sb.push_back('{pat_data, 32'(pat_class)}); pend = 1; end
    end
    pat_valid = 1'b0; pat_last = 1'b0;
    chk("train learn_done", learn_done, 1);
    chk("train accepted", acc, exp_acc);
    chk("ml_learning_done rise", t_ld - t_acc, HC);
    chk("learn_done delay", t - t_acc, HC + 1);
    chk("ridle flags", flags(), F_RIDLE | {8'b0, exp_err});
    chk("count after train", pattern_count, exp_acc);
  endtask

  task automatic recall(input rv_t r);
    int n = 0;
    bit acked = 0;
    exp_t e;
    chk("recall_ready idle", recall_ready, 1);
    recall_req = 1'b1; recall_data = r.x; recall_tk = r.tk;
    sb.push_back('{r.x, r.tk});
    @(negedge clk);
    recall_req = 1'b0; recall_data = ~r.x; recall_tk = ~r.tk;
    while (!acked && n < 50) begin
      n++;
      chk("recall_ready hold", recall_ready, 0);
      if (recall_ack) begin
        acked = 1; e = sb.pop_front();
        chk("recall ml_x", ml_x, e.x);
        chk("recall rc_tk", rc_tk, e.aux);
        chk("recall latency", n, r.lat);
      end else @(negedge clk);
    end
    chk("recall_ack seen", acked, 1);
    if (!acked) sb.delete();
    @(negedge clk);
    chk("recall_ready after", recall_ready, 1);
    chk("recall_ack single", recall_ack, 0);
    chk("rc_tk holds", rc_tk, r.tk);
  endtask

  initial begin
    rtab[0] = '{x: 128'd22313,  tk: 32'd5,           lat: HC};
    rtab[1] = '{x: 128'd324234, tk: 32'd0,           lat: HC};
    rtab[2] = '{x: '1,          tk: 32'hFFFF_FFFF,   lat: HC};
    rtab[3] = '{x: 128'd1234,   tk: 32'h8000_0000,   lat: HC};

    reset = 1'b0; learn_start = 0; pat_valid = 0; pat_last = 0; recall_req = 0;
    pat_data = '0; pat_class = '0; recall_data = '0; recall_tk = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset flags", flags(), F_RESET);
    chk("reset ml_x", ml_x, 0);
    chk("reset ml_c", ml_c, 0);
    chk("reset rc_tk", rc_tk, 0);
    chk("reset count", pattern_count, 0);
    reset = 1'b1;
    pat_valid = 1'b1; recall_req = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("idle ignores inputs", flags(), F_RESET);
    pat_valid = 1'b0; recall_req = 1'b0;

    // three vectors, class 1, last on the third
    tr_x[0] = 128'd1234; tr_x[1] = 128'd22313; tr_x[2] = 128'd324234;
    for (int i = 0; i < 3; i++) tr_c[i] = 8'd1;
    start_learn();
    train(3, 1'b1, 3, 1'b0);

    foreach (rtab[i]) recall(rtab[i]);
    chk("ml_c through recall", ml_c, 1);
    chk("count through recall", pattern_count, 3);

    // retrain and query in the same cycle: retrain wins, no query accepted
    learn_start = 1'b1; recall_req = 1'b1; recall_data = 128'hABCD; recall_tk = 32'd9;
    @(negedge clk);
    learn_start = 1'b0; recall_req = 1'b0;
    chk("retrain mlrst flags", flags(), F_MLRST);
    chk("retrain count", pattern_count, 0);
    @(negedge clk);
    chk("retrain load flags", flags(), F_LOAD);

    // five vectors without last against a limit of four
    for (int i = 0; i < 5; i++) begin tr_x[i] = 128'h1000 + 128'(i * 7); tr_c[i] = 8'(i + 3); end
    train(5, 1'b0, MAXP, 1'b1);
    chk("overflow ml_c", ml_c, 32'd6);

    // async reset in the middle of the second vector's hold window
    start_learn();
    pat_valid = 1'b1; pat_data = 128'h55; pat_class = 8'd2;
    begin
      int g = 0;
      while (pattern_count != 2 && g < 100) begin @(negedge clk); g++; end
      chk("second accept reached", pattern_count, 2);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async flags", flags(), F_RESET);
    chk("async ml_x", ml_x, 0);
    chk("async ml_c", ml_c, 0);
    chk("async rc_tk", rc_tk, 0);
    chk("async count", pattern_count, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post-reset idle", flags(), F_RESET);
    end
    start_learn();
    @(negedge clk);
    chk("post-reset load", flags(), F_LOAD);
    pat_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
